fetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the instruction memory and also consumes its output. It generates the program counter driven into the memory's PC input and tracks the one-cycle memory latency. It captures each returned {pc, instruction} pair into a small queue and presents that queue to decode with a valid/ready handshake. A branch/jump redirect from downstream flushes the queue and restarts fetch at a new address.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side valid/ready handshake of the fetch queue head.
interface fetch_unit_if;
  import fetch_pkg::*;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [XLEN-1:0] out_instr_o;

  modport master (output out_valid_o, output out_pc_o, output out_instr_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_pc_o, input out_instr_o, output out_ready_i);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous queue of fetched {pc, instr} pairs; presents a NOP head when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic                     head_valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

  always_comb begin
    head_o.pc    = '0;
    head_o.instr = NOP_INSTR;
    if (head_valid_o) head_o = mem_q[rd_ptr_q];
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, one-deep in-flight tracking, credit-based queueing, redirect.
// Optional echo-PC check enabled by defining FETCH_PC_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h00000000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   mem_pc_o,
  input  logic [XLEN-1:0]   mem_pc_i,
  input  logic [XLEN-1:0]   mem_instr_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  fetch_unit_if.master      dec,
  output logic              pc_mismatch_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic            issue, push, pop, head_valid;
  fetch_entry_t    head, push_data;

  // Queued entries plus the outstanding response must never exceed capacity.
  assign issue = !redirect_i && ((count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
  assign push  = inflight_q && !redirect_i;
  assign pop   = head_valid && dec.out_ready_i;

  assign push_data.pc    = mem_pc_i;
  assign push_data.instr = mem_instr_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign mem_pc_o = fetch_pc_q;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect_i),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (count)
  );

  assign dec.out_valid_o = head_valid;
  assign dec.out_pc_o    = head.pc;
  assign dec.out_instr_o = head.instr;

`ifdef FETCH_PC_CHECK_EN
  logic [XLEN-1:0] exp_pc_q, exp_pc_d;
  logic            mismatch_q, mismatch_d;
  logic            unused_ok;

  always_comb begin
    exp_pc_d   = exp_pc_q;
    mismatch_d = mismatch_q;
    if (issue) exp_pc_d = fetch_pc_q;
    if (push && (mem_pc_i != exp_pc_q)) mismatch_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_pc_q   <= RESET_PC;
      mismatch_q <= 1'b0;
    end else begin
      exp_pc_q   <= exp_pc_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign pc_mismatch_o = mismatch_q;
  assign unused_ok     = ^redirect_pc_i[1:0];
`else
  logic unused_ok;
  assign pc_mismatch_o = 1'b0;
  assign unused_ok     = ^{redirect_pc_i[1:0], mem_pc_i};
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered memory model and queue-based scoreboards.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pc_o, mem_pc_i, mem_instr_i;
  logic [31:0] w_mem_pc_o, w_mem_pc_i, w_mem_instr_i;
  logic        redir, w_redir;
  logic [31:0] rpc, w_rpc;
  logic        mism, w_mism;
  logic        corrupt;
  logic [31:0] mpc_q, minstr_q, wpc_q, winstr_q;
  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int h0;
  logic exp_mism;

  fetch_entry_t sb[$];
  fetch_entry_t sbw[$];
  fetch_entry_t e_m, e_w;

  fetch_unit_if dif();
  fetch_unit_if wif();

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .mem_pc_o(mem_pc_o), .mem_pc_i(mem_pc_i),
    .mem_instr_i(mem_instr_i), .redirect_i(redir), .redirect_pc_i(rpc),
    .dec(dif), .pc_mismatch_o(mism)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .reset(reset), .mem_pc_o(w_mem_pc_o), .mem_pc_i(w_mem_pc_i),
    .mem_instr_i(w_mem_instr_i), .redirect_i(w_redir), .redirect_pc_i(w_rpc),
    .dec(wif), .pc_mismatch_o(w_mism)
  );

  // Registered instruction memory: address captured at an edge, data visible after it.
  always @(posedge clk) begin
    mpc_q    <= mem_pc_o;
    minstr_q <= mem[mem_pc_o[9:2]];
    wpc_q    <= w_mem_pc_o;
    winstr_q <= mem[w_mem_pc_o[9:2]];
  end
  assign mem_pc_i      = mpc_q ^ (corrupt ? 32'h10 : 32'h0);
  assign mem_instr_i   = minstr_q;
  assign w_mem_pc_i    = wpc_q;
  assign w_mem_instr_i = winstr_q;

  function automatic logic [31:0] minstr(input logic [31:0] pc);
    return mem[pc[9:2]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    fetch_entry_t e;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = minstr(e.pc);
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && dif.out_valid_o && dif.out_ready_i) begin
      hs_cnt++;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e_m = sb.pop_front();
        chk("out_pc", dif.out_pc_o, e_m.pc);
        chk("out_instr", dif.out_instr_o, e_m.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && wif.out_valid_o && wif.out_ready_i && sbw.size() > 0) begin
      e_w = sbw.pop_front();
      chk("wrap_pc", wif.out_pc_o, e_w.pc);
      chk("wrap_instr", wif.out_instr_o, e_w.instr);
    end
  end

  initial begin
`ifdef FETCH_PC_CHECK_EN
    exp_mism = 1'b1;
`else
    exp_mism = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    reset = 1'b0; corrupt = 1'b0; redir = 1'b0; rpc = '0; w_redir = 1'b0; w_rpc = '0;
    dif.out_ready_i = 1'b0; wif.out_ready_i = 1'b1;
    cyc(2);
    chk("rst_valid", 32'(dif.out_valid_o), 32'd0);
    chk("rst_pc", dif.out_pc_o, 32'h0);
    chk("rst_instr", dif.out_instr_o, NOP_INSTR);
    chk("rst_mem_pc", mem_pc_o, 32'h0);
    chk("rst_mismatch", 32'(mism), 32'd0);
    chk("rst_wrap_mem_pc", w_mem_pc_o, 32'hFFFFFFF8);

    // Streaming from reset
    sb_load(32'h0, 64);
    e_w.pc = 32'hFFFFFFF8; e_w.instr = minstr(e_w.pc); sbw.push_back(e_w);
    e_w.pc = 32'hFFFFFFFC; e_w.instr = minstr(e_w.pc); sbw.push_back(e_w);
    e_w.pc = 32'h00000000; e_w.instr = minstr(e_w.pc); sbw.push_back(e_w);
    dif.out_ready_i = 1'b1;
    reset = 1'b1;
    cyc(1);
    chk("e1_valid", 32'(dif.out_valid_o), 32'd0);
    cyc(1);
    chk("e2_valid", 32'(dif.out_valid_o), 32'd1);
    chk("e2_pc", dif.out_pc_o, 32'h0);
    chk("e2_mem_pc", mem_pc_o, 32'h8);
    h0 = hs_cnt;
    cyc(6);
    chk("throughput", 32'(hs_cnt - h0), 32'd6);

    // Stall: queue fills to capacity and the PC stops 4 words past the head
    dif.out_ready_i = 1'b0;
    cyc(10);
    chk("stall_head", dif.out_pc_o, 32'(4 * hs_cnt));
    chk("stall_mem_pc", mem_pc_o, 32'(4 * hs_cnt + 16));
    cyc(1);
    chk("stall_mem_pc_hold", mem_pc_o, 32'(4 * hs_cnt + 16));
    dif.out_ready_i = 1'b1;
    h0 = hs_cnt;
    cyc(8);
    chk("release_rate", 32'(hs_cnt - h0), 32'd8);

    // Redirect while full
    dif.out_ready_i = 1'b0;
    cyc(6);
    redir = 1'b1; rpc = 32'h103;
    cyc(1);
    redir = 1'b0;
    sb_load(32'h100, 32);
    chk("rd_valid_r0", 32'(dif.out_valid_o), 32'd0);
    cyc(1);
    chk("rd_valid_r1", 32'(dif.out_valid_o), 32'd0);
    cyc(1);
    chk("rd_valid_r2", 32'(dif.out_valid_o), 32'd1);
    chk("rd_head_pc", dif.out_pc_o, 32'h100);
    chk("rd_head_instr", dif.out_instr_o, mem[8'h40]);
    dif.out_ready_i = 1'b1;
    cyc(6);

    // Redirect coinciding with a response and a pop
    redir = 1'b1; rpc = 32'h200;
    h0 = hs_cnt;
    cyc(1);
    redir = 1'b0;
    chk("rp_pop_taken", 32'(hs_cnt - h0), 32'd1);
    sb_load(32'h200, 32);
    chk("rp_valid_r0", 32'(dif.out_valid_o), 32'd0);
    cyc(1);
    chk("rp_valid_r1", 32'(dif.out_valid_o), 32'd0);
    cyc(1);
    chk("rp_head_pc", dif.out_pc_o, 32'h200);
    cyc(5);

    // Back-to-back redirects: the last one wins
    redir = 1'b1; rpc = 32'h300;
    cyc(1);
    rpc = 32'h404;
    cyc(1);
    redir = 1'b0;
    sb_load(32'h404, 32);
    cyc(2);
    chk("b2b_head_pc", dif.out_pc_o, 32'h404);
    cyc(5);

    // Corrupted echo PC on one response
    chk("pre_mismatch", 32'(mism), 32'd0);
    dif.out_ready_i = 1'b0; corrupt = 1'b1;
    cyc(1);
    corrupt = 1'b0; redir = 1'b1; rpc = 32'h500;
    cyc(1);
    redir = 1'b0;
    sb_load(32'h500, 32);
    chk("mismatch_set", 32'(mism), 32'(exp_mism));
    cyc(3);
    dif.out_ready_i = 1'b1;
    cyc(4);
    chk("mismatch_sticky", 32'(mism), 32'(exp_mism));

    // Reset mid-operation
    reset = 1'b0;
    #1;
    sb.delete();
    chk("mrst_valid", 32'(dif.out_valid_o), 32'd0);
    chk("mrst_pc", dif.out_pc_o, 32'h0);
    chk("mrst_instr", dif.out_instr_o, NOP_INSTR);
    chk("mrst_mem_pc", mem_pc_o, 32'h0);
    chk("mrst_mismatch", 32'(mism), 32'd0);
    cyc(2);
    sb_load(32'h0, 16);
    reset = 1'b1;
    cyc(2);
    chk("post_rst_valid", 32'(dif.out_valid_o), 32'd1);
    chk("post_rst_pc", dif.out_pc_o, 32'h0);
    cyc(4);
    chk("wrap_all_seen", 32'(sbw.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
